// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// WIDTH iterations per operation, registered product with a one-cycle done pulse.
module seq_shift_add_mul #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc_next;

  // Running sum after this cycle's conditional add; also the final product.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= PW'(a);
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Last iteration: publish result and return to IDLE in the same edge.
          if (cnt == CW'(WIDTH - 1)) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed self-checking bench for seq_shift_add_mul (WIDTH=4).
module tb_seq_shift_add_mul;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] product;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int prev_done = 0;

  seq_shift_add_mul #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Start one multiply from a negedge; return at the negedge where done is seen.
  task automatic mul(input logic [3:0] ta, input logic [3:0] tb, output int lat,
                     output int busy_cnt, output int held_bad, output int overlap);
    logic [7:0] old_p;
    old_p = product;
    a = ta; b = tb; start = 1'b1;
    lat = 0; busy_cnt = 0; held_bad = 0; overlap = 0;
    @(negedge clk);
    start = 1'b0;
    a = 4'hx; b = 4'hx;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (product != old_p) held_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1;
    a = '0; b = '0;
    prev_done = last_done;
    last_done = cyc;
  endtask

  initial begin
    int lat, bc, hb, ov, nd, gap;
    logic [7:0] p;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
    vecs[5] = '{a: 4'd12, b: 4'd7,  p: 8'd84};
    vecs[6] = '{a: 4'd8,  b: 4'd15, p: 8'd120};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_product", int'(product), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);

    // Table-driven basic multiplies
    for (int i = 0; i < 7; i++) begin
      mul(vecs[i].a, vecs[i].b, lat, bc, hb, ov);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
      chk($sformatf("vec%0d_product", i), int'(product), int'(vecs[i].p));
      chk($sformatf("vec%0d_held_in_run", i), hb, 0);
      chk($sformatf("vec%0d_busy_done_overlap", i), ov, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
      chk($sformatf("vec%0d_product_held", i), int'(product), int'(vecs[i].p));
    end

    // Start while busy is ignored
    a = 4'd7; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; p = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin nd++; p = product; end
    end
    chk("busy_restart_done_count", nd, 1);
    chk("busy_restart_product", int'(p), 42);
    chk("busy_restart_idle_after", int'(busy), 0);

    // Back-to-back with start held through the done cycle
    a = 4'd4; b = 4'd4; start = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_first_latency", lat, 5);
    chk("b2b_first_product", int'(product), 16);
    a = 4'd10; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    gap = 1; hb = 0;
    while (!done && gap < 20) begin
      if (product != 8'd16) hb++;
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, WIDTH + 1);
    chk("b2b_product_held_between", hb, 0);
    chk("b2b_second_product", int'(product), 30);
    @(negedge clk);

    // Reset mid-operation
    a = 4'd13; b = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_product", int'(product), 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("midrst_no_activity", nd, 0);
    mul(4'd2, 4'd3, lat, bc, hb, ov);
    chk("midrst_followup_product", int'(product), 6);
    @(negedge clk);

    // Exhaustive sweep, each start issued in the previous done cycle
    nd = 0; gap = 0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] sa, sb;
      sa = 4'(i >> 4);
      sb = 4'(i);
      mul(sa, sb, lat, bc, hb, ov);
      if (product != 8'(int'(sa) * int'(sb)) || lat != 4) begin
        nd++;
        $display("FAIL sweep a=%0d b=%0d actual=%0d expected=%0d latency=%0d",
                 sa, sb, product, int'(sa) * int'(sb), lat);
      end
      if (i > 0 && last_done - prev_done != WIDTH + 1) gap++;
    end
    chk("sweep_mismatches", nd, 0);
    chk("sweep_spacing_violations", gap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
